frequency_band_analyzer: RTL and testbench

- Parametrised successor of the two-tone frequency counter. Measures the half-period between consecutive edges of one serial input and classifies each interval into one of NUM_BANDS configurable frequency bands with per-band deviation windows.
- Accumulates per-band edge counts and tick sums, with atomic snapshot readout, unmatched-edge count and loss-of-signal detection.
- Sits between the raw demodulator/sampler input and the register/bus readout logic.

---
 rtl/frequency_band_analyzer.sv | 213 +++++++++++++++++++++
 tb/tb_frequency_band_analyzer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/frequency_band_analyzer.sv
// frequency_band_analyzer: measures half-periods of a serial input, classifies
// each interval into one of NUM_BANDS frequency windows and accumulates per-band
// edge counts and tick sums, with an atomic snapshot into readable shadow regs.
// Optional build macro: FREQ_ANALYZER_SATURATE_EN (saturating accumulators plus
// an "overflow" output flag per snapshot window).
`timescale 1ns/1ps

module frequency_band_analyzer #(
  parameter int unsigned                 NUM_BANDS        = 2,
  // band 0 = 11 kHz, band 1 = 9 kHz (band i lives in bits [32i+31:32i])
  parameter logic [32*NUM_BANDS-1:0]     BAND_FREQUENCIES = {32'd9000, 32'd11000},
  parameter int unsigned                 DEVIATION_PCT    = 10,
  parameter int unsigned                 CLOCK_FREQUENCY  = 50000000,
  parameter int unsigned                 COUNT_WIDTH      = 16,
  parameter int unsigned                 LOST_TICKS       = 65535
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   enable,
  input  logic                   sample_data,
  input  logic                   snapshot_req,
  output logic                   snapshot_ack,
  input  logic [2:0]             band_select,
  output logic [31:0]            band_ticks,
  output logic [COUNT_WIDTH-1:0] band_edges,
  output logic [COUNT_WIDTH-1:0] unmatched_edges,
  output logic                   signal_lost
`ifdef FREQ_ANALYZER_SATURATE_EN
  ,
  output logic                   overflow
`endif
);

  localparam int unsigned TW = 32;

  // input path
  logic sync1, sync2, prev;
  logic edge_c;

  // interval measurement
  logic [TW-1:0] half_cnt;
  logic          armed;
  logic          lost_now;
  logic          iv_valid;
  logic [TW-1:0] iv_ticks;

  // classification
  logic [NUM_BANDS-1:0] in_win;
  logic [NUM_BANDS-1:0] hit;
  logic                 no_match;

  // accumulators
  logic [COUNT_WIDTH-1:0] live_edges   [NUM_BANDS];
  logic [COUNT_WIDTH-1:0] shadow_edges [NUM_BANDS];
  logic [COUNT_WIDTH-1:0] base_edges   [NUM_BANDS];
  logic [COUNT_WIDTH-1:0] nxt_edges    [NUM_BANDS];
  logic [TW-1:0]          live_ticks   [NUM_BANDS];
  logic [TW-1:0]          shadow_ticks [NUM_BANDS];
  logic [TW-1:0]          base_ticks   [NUM_BANDS];
  logic [TW-1:0]          add_ticks    [NUM_BANDS];
  logic [TW-1:0]          nxt_ticks    [NUM_BANDS];
  logic [COUNT_WIDTH-1:0] live_unm, shadow_unm, base_unm, nxt_unm;
`ifdef FREQ_ANALYZER_SATURATE_EN
  logic sat_c;
  logic live_ovf, shadow_ovf;
`endif

  assign edge_c   = sync2 ^ prev;
  assign lost_now = (half_cnt == TW'(LOST_TICKS));

  // Two-flop synchroniser plus previous-value register; always running
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= sample_data;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Interval counter, arming and loss-of-signal tracking; registers interval at each edge
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      half_cnt    <= '0;
      armed       <= 1'b0;
      signal_lost <= 1'b0;
      iv_valid    <= 1'b0;
      iv_ticks    <= '0;
    end else begin
      iv_valid <= 1'b0;
      if (!enable) begin
        half_cnt <= '0;
        armed    <= 1'b0;
      end else if (edge_c) begin
        // an edge landing on the loss threshold only re-arms
        half_cnt    <= '0;
        iv_ticks    <= half_cnt + TW'(1);
        iv_valid    <= armed && !lost_now;
        armed       <= 1'b1;
        signal_lost <= 1'b0;
      end else if (lost_now) begin
        signal_lost <= 1'b1;
        armed       <= 1'b0;
      end else begin
        half_cnt <= half_cnt + TW'(1);
      end
    end
  end

  // Per-band inclusive window compare against elaboration-time constants
  for (genvar g = 0; g < NUM_BANDS; g++) begin : g_band
    localparam longint unsigned FREQ  = 64'(BAND_FREQUENCIES[32*g +: 32]);
    localparam longint unsigned TICKS = 64'(CLOCK_FREQUENCY) / (64'd2 * FREQ);
    localparam longint unsigned DEV   = TICKS * 64'(DEVIATION_PCT) / 64'd100;
    localparam longint unsigned LO    = TICKS - DEV;
    localparam longint unsigned HI    = TICKS + DEV;
    assign in_win[g] = iv_valid && (64'(iv_ticks) >= LO) && (64'(iv_ticks) <= HI);
  end

  // Lowest matching band wins: isolate the least-significant set bit
  assign hit      = in_win & (~in_win + NUM_BANDS'(1));
  assign no_match = iv_valid && (in_win == '0);

  // Next live values: a snapshot restarts from zero but keeps the retiring contribution
  always_comb begin
`ifdef FREQ_ANALYZER_SATURATE_EN
    sat_c = 1'b0;
`endif
    for (int i = 0; i < NUM_BANDS; i++) begin
      base_edges[i] = snapshot_req ? '0 : live_edges[i];
      base_ticks[i] = snapshot_req ? '0 : live_ticks[i];
      add_ticks[i]  = hit[i] ? iv_ticks : '0;
      nxt_edges[i]  = base_edges[i] + COUNT_WIDTH'(hit[i]);
      nxt_ticks[i]  = base_ticks[i] + add_ticks[i];
`ifdef FREQ_ANALYZER_SATURATE_EN
      if (hit[i] && (base_edges[i] == '1)) begin
        nxt_edges[i] = '1;
        sat_c        = 1'b1;
      end
      if (nxt_ticks[i] < base_ticks[i]) begin
        nxt_ticks[i] = '1;
        sat_c        = 1'b1;
      end
`endif
    end
    base_unm = snapshot_req ? '0 : live_unm;
    nxt_unm  = base_unm + COUNT_WIDTH'(no_match);
`ifdef FREQ_ANALYZER_SATURATE_EN
    if (no_match && (base_unm == '1)) begin
      nxt_unm = '1;
      sat_c   = 1'b1;
    end
`endif
  end

  // Live accumulators, shadow capture and snapshot acknowledge
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        live_edges[i]   <= '0;
        live_ticks[i]   <= '0;
        shadow_edges[i] <= '0;
        shadow_ticks[i] <= '0;
      end
      live_unm     <= '0;
      shadow_unm   <= '0;
      snapshot_ack <= 1'b0;
`ifdef FREQ_ANALYZER_SATURATE_EN
      live_ovf     <= 1'b0;
      shadow_ovf   <= 1'b0;
`endif
    end else begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        live_edges[i] <= nxt_edges[i];
        live_ticks[i] <= nxt_ticks[i];
      end
      live_unm     <= nxt_unm;
      snapshot_ack <= snapshot_req;
      if (snapshot_req) begin
        for (int i = 0; i < NUM_BANDS; i++) begin
          shadow_edges[i] <= live_edges[i];
          shadow_ticks[i] <= live_ticks[i];
        end
        shadow_unm <= live_unm;
      end
`ifdef FREQ_ANALYZER_SATURATE_EN
      live_ovf <= snapshot_req ? sat_c : (live_ovf | sat_c);
      if (snapshot_req) shadow_ovf <= live_ovf;
`endif
    end
  end

  // Readout mux over shadow registers; out-of-range selects read zero
  always_comb begin
    band_ticks = '0;
    band_edges = '0;
    for (int i = 0; i < NUM_BANDS; i++) begin
      if (band_select == 3'(i)) begin
        band_ticks = shadow_ticks[i];
        band_edges = shadow_edges[i];
      end
    end
  end

  assign unmatched_edges = shadow_unm;
`ifdef FREQ_ANALYZER_SATURATE_EN
  assign overflow = shadow_ovf;
`endif

endmodule

// File: tb/tb_frequency_band_analyzer.sv
// Directed bench for frequency_band_analyzer: band classification, window
// boundaries, loss of signal, snapshot/retire collision and async clear.
// The loss timeout is shortened to keep the run length down; band windows are default.
`timescale 1ns/1ps

module tb_frequency_band_analyzer;

  localparam int unsigned CW   = 16;
  localparam int unsigned LOST = 4095;

  logic          clock;
  logic          clear;
  logic          enable;
  logic          sample_data;
  logic          snapshot_req;
  logic          snapshot_ack;
  logic [2:0]    band_select;
  logic [31:0]   band_ticks;
  logic [CW-1:0] band_edges;
  logic [CW-1:0] unmatched_edges;
  logic          signal_lost;
`ifdef FREQ_ANALYZER_SATURATE_EN
  logic          overflow;
`endif

  int checks = 0;
  int errors = 0;

  frequency_band_analyzer #(
    .COUNT_WIDTH (CW),
    .LOST_TICKS  (LOST)
  ) dut (
    .clock           (clock),
    .clear           (clear),
    .enable          (enable),
    .sample_data     (sample_data),
    .snapshot_req    (snapshot_req),
    .snapshot_ack    (snapshot_ack),
    .band_select     (band_select),
    .band_ticks      (band_ticks),
    .band_edges      (band_edges),
    .unmatched_edges (unmatched_edges),
    .signal_lost     (signal_lost)
`ifdef FREQ_ANALYZER_SATURATE_EN
    ,
    .overflow        (overflow)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // toggle the input n cycles after the previous toggle
  task automatic toggle_after(input int n);
    repeat (n) @(posedge clock);
    #1 sample_data = ~sample_data;
  endtask

  task automatic snap(input string tag);
    @(posedge clock);
    #1 snapshot_req = 1'b1;
    @(posedge clock);
    #1 snapshot_req = 1'b0;
    check({tag, "_ack"}, 32'(snapshot_ack), 32'd1);
    @(posedge clock);
    #1 check({tag, "_ack_low"}, 32'(snapshot_ack), 32'd0);
  endtask

  task automatic rearm();
    enable = 1'b0;
    repeat (2) @(posedge clock);
    #1 enable = 1'b1;
  endtask

  task automatic read_band(input string tag, input logic [2:0] sel,
                           input logic [31:0] exp_edges, input logic [31:0] exp_ticks);
    band_select = sel;
    #1;
    check({tag, "_edges"}, 32'(band_edges), exp_edges);
    check({tag, "_ticks"}, band_ticks, exp_ticks);
  endtask

  initial begin
    clear        = 1'b1;
    enable       = 1'b0;
    sample_data  = 1'b0;
    snapshot_req = 1'b0;
    band_select  = 3'd0;

    // reset state
    #12;
    check("rst_ticks", band_ticks, 32'd0);
    check("rst_edges", 32'(band_edges), 32'd0);
    check("rst_unm", 32'(unmatched_edges), 32'd0);
    check("rst_lost", 32'(signal_lost), 32'd0);
    check("rst_ack", 32'(snapshot_ack), 32'd0);
    @(posedge clock);
    #1 clear = 1'b0;
    enable = 1'b1;

    // 9 kHz: 11 edges at 2777 -> 10 classified into band 1
    for (int i = 0; i < 11; i++) toggle_after(2777);
    repeat (10) @(posedge clock);
    snap("t1");
    read_band("t1_b1", 3'd1, 32'd10, 32'd27770);
    read_band("t1_b0", 3'd0, 32'd0, 32'd0);
    check("t1_unm", 32'(unmatched_edges), 32'd0);

    // 11 kHz: 6 edges at 2272 -> 5 classified into band 0
    rearm();
    for (int i = 0; i < 6; i++) toggle_after(2272);
    repeat (10) @(posedge clock);
    snap("t2");
    read_band("t2_b0", 3'd0, 32'd5, 32'd11360);
    read_band("t2_b1", 3'd1, 32'd0, 32'd0);
    check("t2_unm", 32'(unmatched_edges), 32'd0);

    // 1000-cycle intervals match nothing
    rearm();
    for (int i = 0; i < 4; i++) toggle_after(1000);
    repeat (10) @(posedge clock);
    snap("t3");
    check("t3_unm", 32'(unmatched_edges), 32'd3);
    read_band("t3_b0", 3'd0, 32'd0, 32'd0);
    read_band("t3_b1", 3'd1, 32'd0, 32'd0);

    // window boundaries of band 1 [2500,3054]; 2499 is band 0's upper edge
    rearm();
    toggle_after(100);
    toggle_after(2500);
    toggle_after(3054);
    toggle_after(2499);
    toggle_after(3055);
    repeat (10) @(posedge clock);
    snap("t4");
    read_band("t4_b1", 3'd1, 32'd2, 32'd5554);
    read_band("t4_b0", 3'd0, 32'd1, 32'd2499);
    check("t4_unm", 32'(unmatched_edges), 32'd1);
    read_band("t4_oob", 3'd5, 32'd0, 32'd0);

    // loss of signal, recovery edge only re-arms
    rearm();
    repeat (4000) @(posedge clock);
    #1 check("t5_not_lost", 32'(signal_lost), 32'd0);
    repeat (200) @(posedge clock);
    #1 check("t5_lost", 32'(signal_lost), 32'd1);
    toggle_after(5);
    repeat (4) @(posedge clock);
    #1 check("t5_recovered", 32'(signal_lost), 32'd0);
    toggle_after(2773);
    repeat (10) @(posedge clock);
    snap("t5");
    read_band("t5_b1", 3'd1, 32'd1, 32'd2777);
    read_band("t5_b0", 3'd0, 32'd0, 32'd0);
    check("t5_unm", 32'(unmatched_edges), 32'd0);

    // snapshot collides with retirement of the third classified edge
    rearm();
    toggle_after(100);
    toggle_after(2777);
    toggle_after(2777);
    toggle_after(2777);
    repeat (3) @(posedge clock);
    #1 snapshot_req = 1'b1;
    @(posedge clock);
    #1 snapshot_req = 1'b0;
    check("t6_ack", 32'(snapshot_ack), 32'd1);
    read_band("t6_first", 3'd1, 32'd2, 32'd5554);
    repeat (10) @(posedge clock);
    snap("t6b");
    read_band("t6_second", 3'd1, 32'd1, 32'd2777);

    // asynchronous clear between clock edges
    band_select = 3'd1;
    @(posedge clock);
    #3 clear = 1'b1;
    #1;
    check("clr_edges", 32'(band_edges), 32'd0);
    check("clr_ticks", band_ticks, 32'd0);
    check("clr_unm", 32'(unmatched_edges), 32'd0);
    check("clr_lost", 32'(signal_lost), 32'd0);
    check("clr_ack", 32'(snapshot_ack), 32'd0);
    @(posedge clock);
    #1 clear = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
